// File: rtl/mem_port_arbiter_if.sv
// Native memory-port bundle (valid/ready, addr/wdata/wstrb/rdata) shared by masters and the slave.
// Latency: none; this file only declares wires.
// Backpressure: the requester holds valid until the responder returns a one-cycle ready pulse.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                valid;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                ready;
  logic [DATA_W-1:0]   rdata;

  // Requester side (core, accelerator DMA, or the arbiter towards memory)
  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  // Responder side (memory, or the arbiter towards each master)
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one native memory port between the core (m0) and SHA DMA (m1); optional ARB_TIMEOUT_EN adds a response timeout.
// Latency: 1 cycle valid->grant; request and response pass combinationally while granted; 1 idle cycle after each completion.
// Backpressure: losing master waits with valid held; memory stalls by withholding s_ready (forever unless ARB_TIMEOUT_EN).
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  m0,
  mem_port_arbiter_if.slave  m1,
  mem_port_arbiter_if.master s,
  output logic               grant_id,
  output logic               busy,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   grant_id_q, grant_id_d;
  logic   busy_q, busy_d;

  logic                cur_valid;
  logic                tout;
  logic [ADDR_W-1:0]   addr_mux;
  logic [DATA_W-1:0]   wdata_mux;
  logic [DATA_W/8-1:0] wstrb_mux;
  logic [DATA_W-1:0]   rdata_fwd;

  // Valid of whichever master currently owns the port
  always_comb begin
    cur_valid = grant_id_q ? m1.valid : m0.valid;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = 16;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Timeout fires only if the memory has not answered in this same cycle
  assign tout = (state_q != IDLE) && cur_valid && !s.ready &&
                (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Count stalled cycles of the current grant; err is sticky until reset
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!s.ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (tout) begin
      err_d = 1'b1;
    end
  end

  // Timeout counter and error flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;

  assign tout           = 1'b0;
  assign err            = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Next-state: grant from IDLE with round-robin tie-break, release on completion/abort/timeout
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (m0.valid && (!m1.valid || last_grant_q)) begin
          state_d    = GRANT0;
          grant_id_d = 1'b0;
          busy_d     = 1'b1;
        end else if (m1.valid) begin
          state_d    = GRANT1;
          grant_id_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      default: begin
        if (!cur_valid) begin
          // Master withdrew its request: drop it without touching fairness state
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (s.ready || tout) begin
          state_d      = IDLE;
          busy_d       = 1'b0;
          last_grant_d = grant_id_q;
        end
      end
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      busy_q       <= busy_d;
    end
  end

  // Steer the owning master onto the memory port and the response back; everything else is zero
  always_comb begin
    s.valid   = 1'b0;
    addr_mux  = '0;
    wdata_mux = '0;
    wstrb_mux = '0;
    m0.ready  = 1'b0;
    m1.ready  = 1'b0;
    m0.rdata  = '0;
    m1.rdata  = '0;
    rdata_fwd = tout ? DATA_W'(32'hDEADBEEF) : s.rdata;
    if (state_q == GRANT0) begin
      s.valid   = m0.valid;
      addr_mux  = m0.addr;
      wdata_mux = m0.wdata;
      wstrb_mux = m0.wstrb;
      m0.ready  = m0.valid && (s.ready || tout);
      m0.rdata  = rdata_fwd;
    end else if (state_q == GRANT1) begin
      s.valid   = m1.valid;
      addr_mux  = m1.addr;
      wdata_mux = m1.wdata;
      wstrb_mux = m1.wstrb;
      m1.ready  = m1.valid && (s.ready || tout);
      m1.rdata  = rdata_fwd;
    end
  end

  assign s.addr   = addr_mux;
  assign s.wdata  = wdata_mux;
  assign s.wstrb  = wstrb_mux;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then randomized traffic.
// A transaction-level model (owner / last winner / stall count) predicts every output each cycle.
// Inputs change 1 time unit after the rising edge; the model compares on the falling edge.
module tb_mem_port_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO_CYC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic grant_id, busy, err;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if), .s(s_if),
    .grant_id(grant_id), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic rdy_seen [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  int owner    = -1;   // -1: port free, else index of the master holding it
  int last_win = 1;    // master that most recently completed
  int gid      = 0;
  int stall    = 0;    // cycles the current grant has gone without a response
  int err_m    = 0;

  initial begin
    logic v, to;
    logic [31:0] e_sa, e_sd, e_ss, e_r0, e_r1, e_d0, e_d1, e_sv;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_sv = 0; e_sa = 0; e_sd = 0; e_ss = 0; e_r0 = 0; e_r1 = 0; e_d0 = 0; e_d1 = 0;
      v = 1'b0; to = 1'b0;
      if (owner >= 0) begin
        v  = (owner == 0) ? m0_if.valid : m1_if.valid;
        to = TO_EN && v && !s_if.ready && (stall == TO_CYC);
        e_sv = {31'b0, v};
        e_sa = (owner == 0) ? m0_if.addr  : m1_if.addr;
        e_sd = (owner == 0) ? m0_if.wdata : m1_if.wdata;
        e_ss = {28'b0, (owner == 0) ? m0_if.wstrb : m1_if.wstrb};
        if (owner == 0) begin
          e_r0 = {31'b0, v && (s_if.ready || to)};
          e_d0 = to ? 32'hDEADBEEF : s_if.rdata;
        end else begin
          e_r1 = {31'b0, v && (s_if.ready || to)};
          e_d1 = to ? 32'hDEADBEEF : s_if.rdata;
        end
      end
      chk("m_busy",     busy,        (owner >= 0) ? 1 : 0);
      chk("m_grant_id", grant_id,    gid);
      chk("m_err",      err,         err_m);
      chk("m_s_valid",  s_if.valid,  e_sv);
      chk("m_s_addr",   s_if.addr,   e_sa);
      chk("m_s_wdata",  s_if.wdata,  e_sd);
      chk("m_s_wstrb",  s_if.wstrb,  e_ss);
      chk("m_m0_ready", m0_if.ready, e_r0);
      chk("m_m1_ready", m1_if.ready, e_r1);
      chk("m_m0_rdata", m0_if.rdata, e_d0);
      chk("m_m1_rdata", m1_if.rdata, e_d1);
      rdy_seen[0] = m0_if.ready;
      rdy_seen[1] = m1_if.ready;
      // advance the model with the inputs the DUT sees at the coming edge
      if (rst) begin
        owner = -1; last_win = 1; gid = 0; stall = 0; err_m = 0;
      end else if (owner < 0) begin
        if (m0_if.valid || m1_if.valid) begin
          if (m0_if.valid && m1_if.valid) owner = 1 - last_win;
          else                            owner = m0_if.valid ? 0 : 1;
          gid   = owner;
          stall = 0;
        end
      end else if (!v) begin
        owner = -1;
      end else if (s_if.ready || to) begin
        if (!s_if.ready) err_m = 1;
        last_win = owner;
        owner    = -1;
      end else begin
        stall++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    m0_if.valid = v; m0_if.addr = a; m0_if.wdata = d; m0_if.wstrb = s;
  endtask

  task automatic set_m1(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    m1_if.valid = v; m1_if.addr = a; m1_if.wdata = d; m1_if.wstrb = s;
  endtask

  logic        vld [2];
  logic [31:0] ra  [2];
  logic [31:0] rd  [2];
  logic [3:0]  rs  [2];

  initial begin
    set_m0(0, 0, 0, 0);
    set_m1(0, 0, 0, 0);
    s_if.ready = 0; s_if.rdata = 0;
    cyc(); cyc();
    rst = 0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_err", err, 0);
    chk("rst_s_valid", s_if.valid, 0);
    chk("rst_m0_ready", m0_if.ready, 0);
    chk("rst_m1_ready", m1_if.ready, 0);

    // single core read
    cyc(); set_m0(1, 32'h100, 0, 4'h0); #2;
    chk("rd_idle_s_valid", s_if.valid, 0);
    cyc(); #2;
    chk("rd_busy", busy, 1);
    chk("rd_s_valid", s_if.valid, 1);
    chk("rd_s_addr", s_if.addr, 32'h100);
    chk("rd_s_wstrb", s_if.wstrb, 0);
    chk("rd_m0_ready_wait", m0_if.ready, 0);
    cyc(); #2;
    chk("rd_m0_ready_wait2", m0_if.ready, 0);
    cyc(); s_if.ready = 1; s_if.rdata = 32'h12345678; #2;
    chk("rd_m0_ready", m0_if.ready, 1);
    chk("rd_m0_rdata", m0_if.rdata, 32'h12345678);
    chk("rd_m1_ready", m1_if.ready, 0);
    chk("rd_m1_rdata", m1_if.rdata, 0);
    cyc(); s_if.ready = 0; set_m0(0, 0, 0, 0); #2;
    chk("rd_done_busy", busy, 0);
    chk("rd_done_m0_ready", m0_if.ready, 0);

    // simultaneous requests straight after reset: core wins
    cyc(); rst = 1;
    cyc(); rst = 0;
    set_m0(1, 32'h10, 32'hCAFEF00D, 4'hF);
    set_m1(1, 32'h200, 0, 4'h0);
    #2; chk("sim_idle_busy", busy, 0);
    cyc(); s_if.ready = 1; s_if.rdata = 0; #2;
    chk("sim_grant0", grant_id, 0);
    chk("sim_s_addr", s_if.addr, 32'h10);
    chk("sim_s_wdata", s_if.wdata, 32'hCAFEF00D);
    chk("sim_s_wstrb", s_if.wstrb, 4'hF);
    chk("sim_m0_ready", m0_if.ready, 1);
    chk("sim_m1_ready_low", m1_if.ready, 0);
    cyc(); set_m0(0, 0, 0, 0); s_if.ready = 0; #2;
    chk("sim_gap_busy", busy, 0);
    chk("sim_gap_m1_ready", m1_if.ready, 0);
    cyc(); s_if.ready = 1; s_if.rdata = 32'hA5A50001; #2;
    chk("sim_grant1", grant_id, 1);
    chk("sim_s_addr1", s_if.addr, 32'h200);
    chk("sim_m1_ready", m1_if.ready, 1);
    chk("sim_m1_rdata", m1_if.rdata, 32'hA5A50001);
    chk("sim_m0_ready_low", m0_if.ready, 0);
    cyc(); set_m1(0, 0, 0, 0); s_if.ready = 0; #2;
    chk("sim_end_busy", busy, 0);

    // sustained contention: 0,1,0,1,0,1 with one idle cycle between
    cyc(); set_m0(1, 32'h40, 1, 4'h1); set_m1(1, 32'h80, 2, 4'h2); s_if.ready = 1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) cyc();
      #2;
      chk("rr_busy", busy, i % 2);
      if (i % 2 == 1) begin
        chk("rr_grant", grant_id, (i / 2) % 2);
        chk("rr_ready_owner", ((i / 2) % 2 == 0) ? m0_if.ready : m1_if.ready, 1);
      end
    end
    cyc(); set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0); s_if.ready = 0;

    // abort: accelerator drops valid while granted, core then served
    cyc(); set_m1(1, 32'h300, 0, 0);
    cyc(); set_m0(1, 32'h44, 32'h5, 4'h3); set_m1(0, 0, 0, 0); #2;
    chk("ab_grant1", grant_id, 1);
    chk("ab_busy", busy, 1);
    chk("ab_s_valid", s_if.valid, 0);
    chk("ab_m1_ready", m1_if.ready, 0);
    cyc(); #2;
    chk("ab_idle_busy", busy, 0);
    cyc(); s_if.ready = 1; #2;
    chk("ab_grant0", grant_id, 0);
    chk("ab_m0_ready", m0_if.ready, 1);
    cyc(); set_m0(0, 0, 0, 0); s_if.ready = 0;

    // reset in the middle of a core transaction
    cyc(); set_m0(1, 32'h60, 0, 0);
    cyc(); rst = 1; #2;
    chk("mr_busy_before", busy, 1);
    cyc(); rst = 0; set_m0(0, 0, 0, 0); set_m1(1, 32'h64, 0, 0); #2;
    chk("mr_busy", busy, 0);
    chk("mr_s_valid", s_if.valid, 0);
    chk("mr_m0_ready", m0_if.ready, 0);
    cyc(); s_if.ready = 1; #2;
    chk("mr_grant1", grant_id, 1);
    chk("mr_m1_ready", m1_if.ready, 1);
    cyc(); set_m1(0, 0, 0, 0); s_if.ready = 0;

    if (TO_EN) begin
      // memory never answers: timeout after TO_CYC stalled cycles
      cyc(); set_m0(1, 32'h70, 0, 0);
      for (int k = 0; k <= TO_CYC; k++) begin
        cyc(); #2;
        chk("to_m0_ready", m0_if.ready, (k == TO_CYC) ? 1 : 0);
      end
      chk("to_m0_rdata", m0_if.rdata, 32'hDEADBEEF);
      cyc(); set_m0(0, 0, 0, 0); #2;
      chk("to_err", err, 1);
      cyc(); set_m0(1, 32'h74, 0, 0);
      cyc(); s_if.ready = 1; #2;
      chk("to_next_ready", m0_if.ready, 1);
      cyc(); set_m0(0, 0, 0, 0); s_if.ready = 0; #2;
      chk("to_err_sticky", err, 1);
    end

    // randomized traffic with occasional aborts and resets
    for (int x = 0; x < 2; x++) begin vld[x] = 0; ra[x] = 0; rd[x] = 0; rs[x] = 0; end
    for (int n = 0; n < 4000; n++) begin
      cyc();
      rst = ($urandom_range(0, 299) == 0);
      for (int x = 0; x < 2; x++) begin
        if (vld[x] && rdy_seen[x]) begin
          vld[x] = ($urandom_range(0, 3) == 0);
        end else if (vld[x] && $urandom_range(0, 49) == 0) begin
          vld[x] = 0;
        end else if (!vld[x] && $urandom_range(0, 2) == 0) begin
          vld[x] = 1;
        end
        if (vld[x] && (rdy_seen[x] || !(x == 0 ? m0_if.valid : m1_if.valid))) begin
          ra[x] = $urandom;
          rd[x] = $urandom;
          rs[x] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
        end
      end
      set_m0(vld[0], ra[0], rd[0], rs[0]);
      set_m1(vld[1], ra[1], rd[1], rs[1]);
      s_if.ready = ($urandom_range(0, 2) == 0);
      s_if.rdata = $urandom;
    end
    cyc(); rst = 0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single native memory port (valid/ready, addr/wdata/wstrb/rdata) between the RISC-V core (master 0) and the SHA-256 accelerator's message/digest DMA (master 1).
- Sits between the core/accelerator and the on-chip memory in the top-level.
- Grants one master at a time, uses round-robin on contention, and forwards exactly one transaction per grant.

Parameters:
- ADDR_W, 32, address width for both masters and the slave.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- TIMEOUT_CYCLES, 255, slave-response limit in cycles. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- m0_valid  in  1  core request; held until m0_ready
- m0_addr  in  ADDR_W  core address
- m0_wdata  in  DATA_W  core write data
- m0_wstrb  in  DATA_W/8  core byte strobes; 0 = read
- m0_ready  out  1  one-cycle completion pulse to core
- m0_rdata  out  DATA_W  read data, valid when m0_ready=1
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata  same widths/meanings, accelerator side
- s_valid  out  1  request to memory
- s_addr  out  ADDR_W  forwarded address
- s_wdata  out  DATA_W  forwarded write data
- s_wstrb  out  DATA_W/8  forwarded strobes
- s_ready  in  1  memory completion pulse
- s_rdata  in  DATA_W  memory read data
- grant_id  out  1  master currently owning the port
- busy  out  1  high in GRANT0/GRANT1
- err  out  1  sticky timeout flag; ARB_TIMEOUT_EN only, else tied 0

Behaviour:
- States: IDLE, GRANT0, GRANT1.
- Reset values: state=IDLE, last_grant=1 (so master 0 wins the first contention), grant_id=0, busy=0, err=0, all *_ready=0, s_valid=0.
- IDLE transitions (registered at the clk edge):
  - only m0_valid → GRANT0
  - only m1_valid → GRANT1
  - both → grant the master != last_grant
  - none → stay IDLE
- Grant latency: 1 cycle from valid to grant.
- In GRANTx:
  - s_valid = mx_valid.
  - s_addr/s_wdata/s_wstrb = master x fields (combinational mux on grant_id).
  - mx_ready = s_ready; mx_rdata = s_rdata. The other master's ready stays 0.
  - In IDLE, s_addr/s_wdata/s_wstrb = 0.
- Completion: on s_ready=1 in GRANTx:
  - last_grant<=x, state<=IDLE.
  - One mandatory idle cycle follows before the next grant, so back-to-back ready pulses to the same master never happen.
- Master drops valid while granted (protocol violation) → abort to IDLE next cycle, no ready, last_grant unchanged.
- s_ready while state=IDLE is ignored; no ready is forwarded.
- Fairness: a master continuously requesting under contention is granted at most every second transaction; worst-case wait = one full transaction + 2 cycles.
- Reset asserted mid-transaction → IDLE next edge, outputs to reset values; the in-flight transaction is dropped and no ready is issued.
- mx_rdata for the non-granted master = 0.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entering GRANTx and increments each cycle in GRANTx without s_ready.
  - When the count reaches TIMEOUT_CYCLES, the arbiter pulses mx_ready with mx_rdata=32'hDEADBEEF, sets err (sticky until rst), sets last_grant=x, and returns to IDLE.
  - s_ready arriving in the same cycle as the timeout takes precedence: normal completion, err not set.
- Undefined: no counter; a granted transaction waits indefinitely; err tied 0.

Test Plan:
- Single core read: m0_valid, addr=0x100, wstrb=0; memory ready 2 cycles later with rdata=0x12345678 → s_valid from cycle 1, m0_ready single pulse, m0_rdata=0x12345678, m1_ready=0 throughout.
- Simultaneous requests after reset: m0 write 0x10/0xCAFEF00D, m1 read 0x200 → m0 granted first, s_wdata=0xCAFEF00D, s_wstrb=4'hF; after 1 idle cycle m1 granted.
- Sustained contention, both valid for 6 transactions → grant_id sequence 0,1,0,1,0,1; busy low exactly one cycle between transactions.
- Abort: m1 granted, drops valid before s_ready → IDLE next cycle, no m1_ready; pending m0 granted next (last_grant unchanged = 1 → m0).
- Reset mid-transaction: assert rst while in GRANT0 → next edge busy=0, s_valid=0, m0_ready never pulses; after release, fresh m1 request granted in 1 cycle.
- (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8) s_ready held 0 → m0_ready pulses 8 cycles after grant with rdata=0xDEADBEEF, err=1 and stays 1 through later successful transactions until rst.
